// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - March C- element and FSM types plus per-element lookup helpers
package sram_bist_pkg;

    localparam int OPS_PER_WORD = 10;

    typedef enum logic [2:0] {
        EL_M0 = 3'd0,
        EL_M1 = 3'd1,
        EL_M2 = 3'd2,
        EL_M3 = 3'd3,
        EL_M4 = 3'd4,
        EL_M5 = 3'd5
    } march_elem_e;

    // Encoding order matters: the FSM advances through elements by incrementing.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1    = 4'd2,
        ST_M2    = 4'd3,
        ST_M3    = 4'd4,
        ST_M4    = 4'd5,
        ST_M5    = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } bist_state_e;

    function automatic march_elem_e state_elem(input bist_state_e s);
        case (s)
            ST_M1:   return EL_M1;
            ST_M2:   return EL_M2;
            ST_M3:   return EL_M3;
            ST_M4:   return EL_M4;
            ST_M5:   return EL_M5;
            default: return EL_M0;
        endcase
    endfunction

    function automatic logic elem_is_up(input march_elem_e e);
        return !(e == EL_M3 || e == EL_M4);
    endfunction

    function automatic logic elem_has_read(input march_elem_e e);
        return e != EL_M0;
    endfunction

    function automatic logic elem_has_write(input march_elem_e e);
        return e != EL_M5;
    endfunction

    function automatic logic elem_rd_val(input march_elem_e e);
        return (e == EL_M2 || e == EL_M4);
    endfunction

    function automatic logic elem_wr_val(input march_elem_e e);
        return (e == EL_M1 || e == EL_M3);
    endfunction

endpackage

// File: rtl/sram_1p_bm_array.sv
// rtl/sram_1p_bm_array.sv - behavioural single-port array with bit-masked write and registered read
module sram_1p_bm_array #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_WORDS      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    men,
    input  logic                    wen,
    input  logic                    ren,
    input  logic [P_ADDR_WIDTH-1:0] addr,
    input  logic [P_DATA_WIDTH-1:0] din,
    input  logic [P_DATA_WIDTH-1:0] bm,
    output logic [P_DATA_WIDTH-1:0] dout
);
    localparam int IW = $clog2(P_WORDS);

    logic [P_DATA_WIDTH-1:0] mem [P_WORDS];
    logic                    in_range;
    logic [IW-1:0]           idx;

    // Addresses at or above P_WORDS never touch storage, so they cannot alias.
    assign in_range = {1'b0, addr} < (P_ADDR_WIDTH+1)'(P_WORDS);
    assign idx      = addr[IW-1:0];

    always_ff @(posedge clk) begin
        if (men && wen && in_range) begin
            mem[idx] <= (mem[idx] & ~bm) | (din & bm);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (men && ren) begin
            dout <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/sram_1p_bm_march_bist.sv
// rtl/sram_1p_bm_march_bist.sv - bit-mask single-port SRAM with on-chip March C- BIST controller
module sram_1p_bm_march_bist
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_WORDS      = 1024
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_MEN,
    input  logic                    A_WEN,
    input  logic                    A_REN,
    input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
    input  logic [P_DATA_WIDTH-1:0] A_DIN,
    input  logic [P_DATA_WIDTH-1:0] A_BM,
    output logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_READY,
    input  logic                    A_BIST_START,
    output logic                    A_BIST_BUSY,
    output logic                    A_BIST_DONE,
    output logic                    A_BIST_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR,
    output logic [2:0]              A_BIST_FAIL_ELEM
);
    localparam logic [P_ADDR_WIDTH-1:0] LAST_ADDR = P_ADDR_WIDTH'(P_WORDS - 1);
    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE  = P_ADDR_WIDTH'(1);

    bist_state_e             state, state_nxt;
    march_elem_e             elem, elem_nxt, rd_elem;
    logic [P_ADDR_WIDTH-1:0] b_addr, b_addr_nxt, rd_addr;
    logic                    phase, phase_nxt;
    logic                    op_rd, op_wr, last_op, end_addr;
    logic                    rd_pend, rd_exp;
    logic                    fail;
    logic [P_ADDR_WIDTH-1:0] fail_addr;
    logic [2:0]              fail_elem;
    logic                    start_ok;

    logic                    arr_men, arr_wen, arr_ren;
    logic [P_ADDR_WIDTH-1:0] arr_addr;
    logic [P_DATA_WIDTH-1:0] arr_din, arr_bm;

    assign A_BIST_BUSY      = (state != ST_IDLE) && (state != ST_DONE);
    assign A_BIST_DONE      = (state == ST_DONE);
    assign A_READY          = !A_BIST_BUSY;
    assign A_BIST_FAIL      = fail;
    assign A_BIST_FAIL_ADDR = fail_addr;
    assign A_BIST_FAIL_ELEM = fail_elem;
    assign start_ok         = A_BIST_START && (state == ST_IDLE || state == ST_DONE);

    // phase marks the write half of a read-then-write element; the address only moves after it.
    always_comb begin
        state_nxt  = state;
        b_addr_nxt = b_addr;
        phase_nxt  = phase;
        op_rd      = 1'b0;
        op_wr      = 1'b0;
        last_op    = 1'b0;
        end_addr   = 1'b0;
        elem       = state_elem(state);
        elem_nxt   = state_elem(bist_state_e'(state + 4'd1));
        case (state)
            ST_IDLE, ST_DONE: begin
                if (A_BIST_START) begin
                    state_nxt  = ST_M0;
                    b_addr_nxt = '0;
                    phase_nxt  = 1'b0;
                end
            end
            ST_DRAIN: state_nxt = ST_DONE;
            default: begin
                op_rd    = elem_has_read(elem) && !phase;
                op_wr    = elem_has_write(elem) && (phase || !elem_has_read(elem));
                last_op  = !(elem_has_read(elem) && elem_has_write(elem)) || phase;
                end_addr = elem_is_up(elem) ? (b_addr == LAST_ADDR) : (b_addr == '0);
                if (!last_op) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (!end_addr) begin
                        b_addr_nxt = elem_is_up(elem) ? b_addr + ADDR_ONE : b_addr - ADDR_ONE;
                    end else if (state == ST_M5) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt  = bist_state_e'(state + 4'd1);
                        b_addr_nxt = elem_is_up(elem_nxt) ? '0 : LAST_ADDR;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state     <= ST_IDLE;
            b_addr    <= '0;
            phase     <= 1'b0;
            rd_pend   <= 1'b0;
            rd_exp    <= 1'b0;
            rd_addr   <= '0;
            rd_elem   <= EL_M0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            state   <= state_nxt;
            b_addr  <= b_addr_nxt;
            phase   <= phase_nxt;
            rd_pend <= op_rd;
            rd_exp  <= elem_rd_val(elem);
            rd_addr <= b_addr;
            rd_elem <= elem;
            if (start_ok) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
            end else if (rd_pend && !fail && (A_DOUT != {P_DATA_WIDTH{rd_exp}})) begin
                fail      <= 1'b1;
                fail_addr <= rd_addr;
                fail_elem <= rd_elem;
            end
        end
    end

    always_comb begin
        arr_men  = A_MEN;
        arr_wen  = A_WEN;
        arr_ren  = A_REN;
        arr_addr = A_ADDR;
        arr_din  = A_DIN;
        arr_bm   = A_BM;
        if (A_BIST_BUSY) begin
            arr_men  = 1'b1;
            arr_wen  = op_wr;
            arr_ren  = op_rd;
            arr_addr = b_addr;
            arr_din  = {P_DATA_WIDTH{elem_wr_val(elem)}};
            arr_bm   = '1;
        end
    end

    sram_1p_bm_array #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH),
        .P_WORDS      (P_WORDS)
    ) i_array (
        .clk  (A_CLK),
        .rst  (A_RST),
        .men  (arr_men),
        .wen  (arr_wen),
        .ren  (arr_ren),
        .addr (arr_addr),
        .din  (arr_din),
        .bm   (arr_bm),
        .dout (A_DOUT)
    );

endmodule

// File: tb/tb_sram_1p_bm_march_bist.sv
// tb/tb_sram_1p_bm_march_bist.sv - scoreboard bench for the BIST SRAM (16-word and 10-word instances)
module tb_sram_1p_bm_march_bist;

    typedef struct {
        int         cycles;
        logic       fail;
        logic [4:0] faddr;
        logic [2:0] felem;
    } bist_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    logic       rst_a, men_a, wen_a, ren_a, start_a;
    logic [4:0] addr_a;
    logic [7:0] din_a, bm_a, dout_a;
    logic       ready_a, busy_a, done_a, fail_a;
    logic [4:0] fail_addr_a;
    logic [2:0] fail_elem_a;

    logic       rst_b, men_b, wen_b, ren_b, start_b;
    logic [3:0] addr_b;
    logic [7:0] din_b, bm_b, dout_b;
    logic       ready_b, busy_b, done_b, fail_b;
    logic [3:0] fail_addr_b;
    logic [2:0] fail_elem_b;

    logic [7:0] rd_q_a [$];
    logic [7:0] rd_q_b [$];
    bist_exp_t  bq_a [$];
    bist_exp_t  bq_b [$];

    logic rv_a = 1'b0, rv_b = 1'b0;
    logic busy_a_q = 1'b0, done_a_q = 1'b0, busy_b_q = 1'b0, done_b_q = 1'b0;
    int   e0_a = 0, e0_b = 0;

    sram_1p_bm_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(5), .P_WORDS(16)) dut_a (
        .A_CLK(clk), .A_RST(rst_a), .A_MEN(men_a), .A_WEN(wen_a), .A_REN(ren_a),
        .A_ADDR(addr_a), .A_DIN(din_a), .A_BM(bm_a), .A_DOUT(dout_a), .A_READY(ready_a),
        .A_BIST_START(start_a), .A_BIST_BUSY(busy_a), .A_BIST_DONE(done_a),
        .A_BIST_FAIL(fail_a), .A_BIST_FAIL_ADDR(fail_addr_a), .A_BIST_FAIL_ELEM(fail_elem_a)
    );

    sram_1p_bm_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_WORDS(10)) dut_b (
        .A_CLK(clk), .A_RST(rst_b), .A_MEN(men_b), .A_WEN(wen_b), .A_REN(ren_b),
        .A_ADDR(addr_b), .A_DIN(din_b), .A_BM(bm_b), .A_DOUT(dout_b), .A_READY(ready_b),
        .A_BIST_START(start_b), .A_BIST_BUSY(busy_b), .A_BIST_DONE(done_b),
        .A_BIST_FAIL(fail_b), .A_BIST_FAIL_ADDR(fail_addr_b), .A_BIST_FAIL_ELEM(fail_elem_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rv_a <= men_a & ren_a & ready_a;
        rv_b <= men_b & ren_b & ready_b;
    end

    // Monitor: pops expected read data and BIST outcomes as the DUTs present them.
    always @(negedge clk) begin
        logic [7:0] exp_d;
        bist_exp_t  e;
        if (rv_a) begin
            if (rd_q_a.size() == 0) begin
                nchk++; nerr++; $display("FAIL rd_a_unexpected: got %0h expected none", dout_a);
            end else begin
                exp_d = rd_q_a.pop_front();
                chk("rd_a_data", 32'(dout_a), 32'(exp_d));
            end
        end
        if (rv_b) begin
            if (rd_q_b.size() == 0) begin
                nchk++; nerr++; $display("FAIL rd_b_unexpected: got %0h expected none", dout_b);
            end else begin
                exp_d = rd_q_b.pop_front();
                chk("rd_b_data", 32'(dout_b), 32'(exp_d));
            end
        end
        if (busy_a && !busy_a_q) e0_a = cyc;
        if (busy_b && !busy_b_q) e0_b = cyc;
        if (done_a && !done_a_q) begin
            if (bq_a.size() == 0) begin
                nchk++; nerr++; $display("FAIL bist_a_unexpected_done: got done expected none");
            end else begin
                e = bq_a.pop_front();
                chk("bist_a_cycles", 32'(cyc - e0_a), 32'(e.cycles));
                chk("bist_a_fail", 32'(fail_a), 32'(e.fail));
                chk("bist_a_fail_addr", 32'(fail_addr_a), 32'(e.faddr));
                chk("bist_a_fail_elem", 32'(fail_elem_a), 32'(e.felem));
            end
        end
        if (done_b && !done_b_q) begin
            if (bq_b.size() == 0) begin
                nchk++; nerr++; $display("FAIL bist_b_unexpected_done: got done expected none");
            end else begin
                e = bq_b.pop_front();
                chk("bist_b_cycles", 32'(cyc - e0_b), 32'(e.cycles));
                chk("bist_b_fail", 32'(fail_b), 32'(e.fail));
                chk("bist_b_fail_addr", 32'(fail_addr_b), 32'(e.faddr));
                chk("bist_b_fail_elem", 32'(fail_elem_b), 32'(e.felem));
            end
        end
        busy_a_q = busy_a; done_a_q = done_a;
        busy_b_q = busy_b; done_b_q = done_b;
    end

    task automatic drive(input int d, input logic m, input logic w, input logic r,
                         input logic [7:0] a, input logic [7:0] di, input logic [7:0] b);
        if (d == 0) begin
            men_a = m; wen_a = w; ren_a = r; addr_a = a[4:0]; din_a = di; bm_a = b;
        end else begin
            men_b = m; wen_b = w; ren_b = r; addr_b = a[3:0]; din_b = di; bm_b = b;
        end
    endtask

    // All access tasks start and end at a falling edge.
    task automatic wr(input int d, input logic [7:0] a, input logic [7:0] di, input logic [7:0] b);
        drive(d, 1'b1, 1'b1, 1'b0, a, di, b);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic rd(input int d, input logic [7:0] a, input logic [7:0] exp);
        if (d == 0) rd_q_a.push_back(exp); else rd_q_b.push_back(exp);
        drive(d, 1'b1, 1'b0, 1'b1, a, 8'h0, 8'h0);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic rdwr(input int d, input logic [7:0] a, input logic [7:0] di, input logic [7:0] exp);
        if (d == 0) rd_q_a.push_back(exp); else rd_q_b.push_back(exp);
        drive(d, 1'b1, 1'b1, 1'b1, a, di, 8'hFF);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic start_bist(input int d, input logic push, input int cycles,
                              input logic f, input logic [4:0] fa, input logic [2:0] fe);
        bist_exp_t e;
        e.cycles = cycles; e.fail = f; e.faddr = fa; e.felem = fe;
        if (push) begin
            if (d == 0) bq_a.push_back(e); else bq_b.push_back(e);
        end
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_hi;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        chk("rst_dout_a", 32'(dout_a), 32'h0);
        chk("rst_busy_a", 32'(busy_a), 32'h0);
        chk("rst_done_a", 32'(done_a), 32'h0);
        chk("rst_fail_a", 32'(fail_a), 32'h0);
        chk("rst_faddr_a", 32'(fail_addr_a), 32'h0);
        chk("rst_felem_a", 32'(fail_elem_a), 32'h0);
        chk("rst_ready_a", 32'(ready_a), 32'h1);
        chk("rst_dout_b", 32'(dout_b), 32'h0);
        chk("rst_ready_b", 32'(ready_b), 32'h1);

        wr(0, 8'd3, 8'hFF, 8'hFF);
        wr(0, 8'd3, 8'h00, 8'h0F);
        rd(0, 8'd3, 8'hF0);
        wr(0, 8'd7, 8'h5A, 8'hFF);
        rdwr(0, 8'd7, 8'h33, 8'h5A);
        rd(0, 8'd7, 8'h33);
        drive(0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h0, 8'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        chk("men0_hold_a", 32'(dout_a), 32'h33);

        start_bist(0, 1'b1, 161, 1'b0, 5'd0, 3'd0);
        chk("start_busy_a", 32'(busy_a), 32'h1);
        rdy_hi = 0;
        for (int k = 1; k <= 200 && !done_a; k++) begin
            if (k == 155) drive(0, 1'b1, 1'b1, 1'b0, 8'd2, 8'hAA, 8'hFF);
            else drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
            start_a = (k == 50);
            @(negedge clk);
            if (ready_a && !done_a) rdy_hi++;
        end
        drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        start_a = 1'b0;
        chk("clean_done_a", 32'(done_a), 32'h1);
        chk("ready_low_while_busy_a", 32'(rdy_hi), 32'h0);
        chk("ready_after_done_a", 32'(ready_a), 32'h1);
        rd(0, 8'd2, 8'h00);
        rd(0, 8'd3, 8'h00);
        rd(0, 8'd15, 8'h00);

        start_bist(0, 1'b1, 161, 1'b1, 5'd5, 3'd3);
        for (int k = 1; k <= 200 && !done_a; k++) begin
            @(negedge clk);
            if (k >= 50 && !done_a) dut_a.i_array.mem[5][0] = 1'b1;
            if (k == 110) begin
                chk("sa1_mid_fail", 32'(fail_a), 32'h1);
                chk("sa1_mid_addr", 32'(fail_addr_a), 32'd5);
                chk("sa1_mid_elem", 32'(fail_elem_a), 32'd3);
            end
        end
        chk("sa1_done_a", 32'(done_a), 32'h1);

        start_bist(0, 1'b1, 161, 1'b1, 5'd5, 3'd2);
        chk("restart_fail_clr", 32'(fail_a), 32'h0);
        chk("restart_faddr_clr", 32'(fail_addr_a), 32'h0);
        chk("restart_done_clr", 32'(done_a), 32'h0);
        for (int k = 1; k <= 200 && !done_a; k++) begin
            @(negedge clk);
            if (k >= 50 && !done_a) dut_a.i_array.mem[5][0] = 1'b0;
            if (k == 70) begin
                chk("sa0_mid_fail", 32'(fail_a), 32'h1);
                chk("sa0_mid_addr", 32'(fail_addr_a), 32'd5);
                chk("sa0_mid_elem", 32'(fail_elem_a), 32'd2);
            end
        end
        chk("sa0_done_a", 32'(done_a), 32'h1);

        wr(1, 8'd4, 8'h11, 8'hFF);
        wr(1, 8'd12, 8'h77, 8'hFF);
        rd(1, 8'd4, 8'h11);
        rd(1, 8'd12, 8'h00);
        wr(1, 8'd9, 8'h3C, 8'hFF);
        rd(1, 8'd9, 8'h3C);

        start_bist(1, 1'b0, 0, 1'b0, 5'd0, 3'd0);
        repeat (39) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("midrst_busy_b", 32'(busy_b), 32'h0);
        chk("midrst_done_b", 32'(done_b), 32'h0);
        chk("midrst_fail_b", 32'(fail_b), 32'h0);
        chk("midrst_ready_b", 32'(ready_b), 32'h1);
        rst_b = 1'b0;
        @(negedge clk);

        start_bist(1, 1'b1, 101, 1'b0, 5'd0, 3'd0);
        for (int k = 1; k <= 150 && !done_b; k++) begin
            @(negedge clk);
            if (k == 50) chk("down_first_addr_b", 32'(dut_b.i_array.addr), 32'd9);
            if (k == 52) chk("down_second_addr_b", 32'(dut_b.i_array.addr), 32'd8);
        end
        chk("clean_done_b", 32'(done_b), 32'h1);
        rd(1, 8'd9, 8'h00);
        rd(1, 8'd0, 8'h00);

        repeat (3) @(negedge clk);
        chk("rd_q_a_empty", 32'(rd_q_a.size()), 32'd0);
        chk("rd_q_b_empty", 32'(rd_q_b.size()), 32'd0);
        chk("bq_a_empty", 32'(bq_a.size()), 32'd0);
        chk("bq_b_empty", 32'(bq_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
